// File: rtl/spc7110_datarom_server.sv
// SPC7110 data-ROM responder: arbitrates the direct read port and the
// decompression unit onto one PSRAM read channel. The direct port keeps a
// one-byte tagged latch so a repeated address needs no PSRAM access.
module spc7110_datarom_server #(
   parameter int PSRAM_LATENCY = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        direct_rom_rd,
   input  logic [23:0] direct_mapped_addr,
   output logic [7:0]  direct_data,
   output logic        direct_data_valid,
   input  logic        decomp_req,
   input  logic [23:0] decomp_addr,
   output logic        decomp_busy,
   output logic        decomp_ack,
   output logic [7:0]  decomp_data,
   output logic [23:0] psram_addr,
   output logic        psram_rd,
   input  logic [7:0]  psram_data
);

   localparam logic [3:0] LAST_CNT = 4'(PSRAM_LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t      state_r, next_state_s;
   logic [3:0]  cnt_r;
   logic        owner_direct_r;
   logic [23:0] psram_addr_r;
   logic        psram_rd_r;
   logic [7:0]  direct_data_r;
   logic [23:0] tag_r;
   logic        tag_valid_r;
   logic        decomp_busy_r;
   logic        decomp_ack_r;
   logic [7:0]  decomp_data_r;
   logic [23:0] decomp_addr_r;

   logic        need_direct_s;
   logic        start_direct_s;
   logic        start_decomp_s;
   logic        fetch_last_s;

   // A direct read needs PSRAM only when the latch does not already hold its address.
   assign need_direct_s = direct_rom_rd & (~tag_valid_r | (tag_r != direct_mapped_addr));

   assign direct_data_valid = tag_valid_r & (tag_r == direct_mapped_addr) & direct_rom_rd;
   assign direct_data       = direct_data_r;
   assign decomp_busy       = decomp_busy_r;
   assign decomp_ack        = decomp_ack_r;
   assign decomp_data       = decomp_data_r;
   assign psram_addr        = psram_addr_r;
   assign psram_rd          = psram_rd_r;

   // FSM state register.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic and arbitration; direct wins, and only IDLE may start a fetch.
   always_comb begin
      next_state_s   = state_r;
      start_direct_s = 1'b0;
      start_decomp_s = 1'b0;
      fetch_last_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (need_direct_s) begin
               start_direct_s = 1'b1;
               next_state_s   = ST_FETCH;
            end else if (decomp_busy_r) begin
               start_decomp_s = 1'b1;
               next_state_s   = ST_FETCH;
            end else begin
               next_state_s   = ST_IDLE;
            end
         end
         ST_FETCH: begin
            if (cnt_r == LAST_CNT) begin
               fetch_last_s = 1'b1;
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_FETCH;
            end
         end
         ST_DONE: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // PSRAM channel: strobe, address, owner and latency counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         psram_rd_r     <= 1'b0;
         psram_addr_r   <= 24'h000000;
         owner_direct_r <= 1'b0;
         cnt_r          <= 4'd0;
      end else if (start_direct_s || start_decomp_s) begin
         psram_rd_r     <= 1'b1;
         psram_addr_r   <= start_direct_s ? direct_mapped_addr : decomp_addr_r;
         owner_direct_r <= start_direct_s;
         cnt_r          <= 4'd0;
      end else if (fetch_last_s) begin
         psram_rd_r     <= 1'b0;
         cnt_r          <= 4'd0;
      end else if (state_r == ST_FETCH) begin
         cnt_r          <= cnt_r + 4'd1;
      end else begin
         psram_rd_r     <= 1'b0;
      end
   end

   // Direct latch: captured byte is tagged with the address that was fetched,
   // not the address currently presented.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         direct_data_r <= 8'h00;
         tag_r         <= 24'h000000;
         tag_valid_r   <= 1'b0;
      end else if (fetch_last_s && owner_direct_r) begin
         direct_data_r <= psram_data;
         tag_r         <= psram_addr_r;
         tag_valid_r   <= 1'b1;
      end else begin
         tag_valid_r   <= tag_valid_r;
      end
   end

   // Decompression side: accept one request at a time, answer with a one-cycle ack.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         decomp_busy_r <= 1'b0;
         decomp_ack_r  <= 1'b0;
         decomp_data_r <= 8'h00;
         decomp_addr_r <= 24'h000000;
      end else begin
         decomp_ack_r <= 1'b0;
         if (fetch_last_s && !owner_direct_r) begin
            decomp_data_r <= psram_data;
            decomp_ack_r  <= 1'b1;
            decomp_busy_r <= 1'b0;
         end else if (decomp_req && !decomp_busy_r) begin
            decomp_addr_r <= decomp_addr;
            decomp_busy_r <= 1'b1;
         end else begin
            decomp_busy_r <= decomp_busy_r;
         end
      end
   end

endmodule

// File: tb/tb_spc7110_datarom_server.sv
// Directed testbench for spc7110_datarom_server with PSRAM_LATENCY=4.
module tb_spc7110_datarom_server;

   logic        CLK;
   logic        RESET;
   logic        direct_rom_rd;
   logic [23:0] direct_mapped_addr;
   logic [7:0]  direct_data;
   logic        direct_data_valid;
   logic        decomp_req;
   logic [23:0] decomp_addr;
   logic        decomp_busy;
   logic        decomp_ack;
   logic [7:0]  decomp_data;
   logic [23:0] psram_addr;
   logic        psram_rd;
   logic [7:0]  psram_data;

   int checks;
   int errors;

   spc7110_datarom_server #(.PSRAM_LATENCY(4)) dut (
      .CLK               (CLK),
      .RESET             (RESET),
      .direct_rom_rd     (direct_rom_rd),
      .direct_mapped_addr(direct_mapped_addr),
      .direct_data       (direct_data),
      .direct_data_valid (direct_data_valid),
      .decomp_req        (decomp_req),
      .decomp_addr       (decomp_addr),
      .decomp_busy       (decomp_busy),
      .decomp_ack        (decomp_ack),
      .decomp_data       (decomp_data),
      .psram_addr        (psram_addr),
      .psram_rd          (psram_rd),
      .psram_data        (psram_data)
   );

   // Clock generation.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // PSRAM content model.
   function automatic logic [7:0] mem_byte(input logic [23:0] a);
      case (a)
         24'h100020: mem_byte = 8'h5A;
         24'h123456: mem_byte = 8'hC3;
         24'h100000: mem_byte = 8'h11;
         24'h200000: mem_byte = 8'h22;
         24'h100010: mem_byte = 8'hA1;
         24'h100011: mem_byte = 8'hB2;
         default:    mem_byte = a[7:0] ^ 8'h3C;
      endcase
   endfunction

   // PSRAM read data follows the presented address.
   always_comb begin
      psram_data = mem_byte(psram_addr);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      RESET = 1'b0;
      direct_rom_rd = 1'b0;
      direct_mapped_addr = 24'h000000;
      decomp_req = 1'b0;
      decomp_addr = 24'h000000;

      // Reset state
      tick(); tick();
      chk("rst_psram_rd", psram_rd, 1'b0);
      chk("rst_psram_addr", psram_addr, 24'h0);
      chk("rst_direct_data", direct_data, 8'h0);
      chk("rst_busy", decomp_busy, 1'b0);
      chk("rst_ack", decomp_ack, 1'b0);
      chk("rst_decomp_data", decomp_data, 8'h0);
      RESET = 1'b1;
      tick();

      // 1: direct fetch of 0x100020, then hold without further access
      direct_rom_rd = 1'b1;
      direct_mapped_addr = 24'h100020;
      chk("t1_valid_N", direct_data_valid, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t1_rd", psram_rd, 1'b1);
         chk("t1_addr", psram_addr, 24'h100020);
         chk("t1_valid_pend", direct_data_valid, 1'b0);
      end
      tick();
      chk("t1_rd_done", psram_rd, 1'b0);
      chk("t1_data", direct_data, 8'h5A);
      chk("t1_valid", direct_data_valid, 1'b1);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("t1_hold_rd", psram_rd, 1'b0);
         chk("t1_hold_valid", direct_data_valid, 1'b1);
      end

      // 2: decomp fetch of 0x123456, second request during busy ignored
      decomp_req = 1'b1;
      decomp_addr = 24'h123456;
      tick();
      decomp_req = 1'b0;
      chk("t2_busy_set", decomp_busy, 1'b1);
      chk("t2_rd_idle", psram_rd, 1'b0);
      tick();
      decomp_req = 1'b1;
      decomp_addr = 24'h0BADAD;
      chk("t2_rd1", psram_rd, 1'b1);
      chk("t2_addr", psram_addr, 24'h123456);
      for (int i = 2; i <= 4; i++) begin
         tick();
         decomp_req = 1'b0;
         chk("t2_rd", psram_rd, 1'b1);
         chk("t2_busy", decomp_busy, 1'b1);
         chk("t2_ack_early", decomp_ack, 1'b0);
      end
      tick();
      chk("t2_ack", decomp_ack, 1'b1);
      chk("t2_data", decomp_data, 8'hC3);
      chk("t2_busy_clr", decomp_busy, 1'b0);
      tick();
      chk("t2_ack_pulse", decomp_ack, 1'b0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t2_one_fetch", psram_rd, 1'b0);
         chk("t2_data_hold", decomp_data, 8'hC3);
      end

      // 3: simultaneous direct and decomp requests, direct first
      direct_mapped_addr = 24'h100000;
      decomp_req = 1'b1;
      decomp_addr = 24'h200000;
      tick();
      decomp_req = 1'b0;
      chk("t3_rd_dir", psram_rd, 1'b1);
      chk("t3_addr_dir", psram_addr, 24'h100000);
      chk("t3_busy", decomp_busy, 1'b1);
      tick(); tick(); tick();
      tick();
      chk("t3_dir_data", direct_data, 8'h11);
      chk("t3_dir_valid", direct_data_valid, 1'b1);
      chk("t3_rd_done", psram_rd, 1'b0);
      tick();
      chk("t3_rd_idle", psram_rd, 1'b0);
      tick();
      chk("t3_rd_dec", psram_rd, 1'b1);
      chk("t3_addr_dec", psram_addr, 24'h200000);
      tick(); tick(); tick();
      tick();
      chk("t3_ack", decomp_ack, 1'b1);
      chk("t3_dec_data", decomp_data, 8'h22);
      tick();

      // 4: direct request appears while a decomp fetch is in flight
      direct_rom_rd = 1'b0;
      decomp_req = 1'b1;
      decomp_addr = 24'h0A0B0C;
      tick();
      decomp_req = 1'b0;
      tick();
      chk("t4_rd_dec", psram_rd, 1'b1);
      tick();
      direct_rom_rd = 1'b1;
      direct_mapped_addr = 24'h100040;
      #1;
      chk("t4_valid_inflight", direct_data_valid, 1'b0);
      tick();
      chk("t4_addr_kept", psram_addr, 24'h0A0B0C);
      tick();
      chk("t4_addr_kept2", psram_addr, 24'h0A0B0C);
      tick();
      chk("t4_ack", decomp_ack, 1'b1);
      chk("t4_dec_data", decomp_data, 8'h30);
      chk("t4_valid_dec_done", direct_data_valid, 1'b0);
      tick();
      chk("t4_rd_idle", psram_rd, 1'b0);
      tick();
      chk("t4_rd_dir", psram_rd, 1'b1);
      chk("t4_addr_dir", psram_addr, 24'h100040);
      chk("t4_valid_pend", direct_data_valid, 1'b0);
      tick(); tick(); tick();
      chk("t4_valid_pend2", direct_data_valid, 1'b0);
      tick();
      chk("t4_valid", direct_data_valid, 1'b1);
      chk("t4_dir_data", direct_data, 8'h7C);

      // 5: direct address changes mid-fetch
      tick();
      direct_mapped_addr = 24'h100010;
      tick();
      chk("t5_addr_old", psram_addr, 24'h100010);
      tick();
      direct_mapped_addr = 24'h100011;
      tick(); tick();
      tick();
      chk("t5_valid_done", direct_data_valid, 1'b0);
      chk("t5_old_data", direct_data, 8'hA1);
      tick();
      chk("t5_rd_idle", psram_rd, 1'b0);
      tick();
      chk("t5_rd_new", psram_rd, 1'b1);
      chk("t5_addr_new", psram_addr, 24'h100011);
      tick(); tick(); tick();
      tick();
      chk("t5_valid_new", direct_data_valid, 1'b1);
      chk("t5_new_data", direct_data, 8'hB2);

      // 6: reset asserted during the second FETCH cycle of a decomp fetch
      tick();
      direct_rom_rd = 1'b0;
      decomp_req = 1'b1;
      decomp_addr = 24'h123456;
      tick();
      decomp_req = 1'b0;
      tick();
      chk("t6_rd_c1", psram_rd, 1'b1);
      tick();
      chk("t6_rd_c2", psram_rd, 1'b1);
      RESET = 1'b0;
      direct_rom_rd = 1'b1;
      direct_mapped_addr = 24'h100020;
      #1;
      chk("t6_rd_drop", psram_rd, 1'b0);
      chk("t6_addr", psram_addr, 24'h0);
      chk("t6_busy", decomp_busy, 1'b0);
      chk("t6_valid", direct_data_valid, 1'b0);
      chk("t6_direct_data", direct_data, 8'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t6_no_ack", decomp_ack, 1'b0);
         chk("t6_dec_data", decomp_data, 8'h0);
      end
      RESET = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         chk("t6_post_rd", psram_rd, 1'b1);
         chk("t6_post_addr", psram_addr, 24'h100020);
         chk("t6_post_no_ack", decomp_ack, 1'b0);
      end
      tick();
      chk("t6_post_valid", direct_data_valid, 1'b1);
      chk("t6_post_data", direct_data, 8'h5A);
      chk("t6_post_ack", decomp_ack, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
